// File: rtl/sunflower_pkg.sv
// sunflower_pkg: shared state encoding, default widths and angle/voltage types for the tracker.
package sunflower_pkg;
    localparam int DEF_ADC_W = 12;
    localparam int DEF_ANG_W = 8;
    typedef enum logic [3:0] {
        IDLE, MOVE, SETTLE, SAMPLE, WAIT_ADC, NEXT, PARK, PARK_SETTLE, DONE
    } scan_state_t;
    typedef logic [DEF_ANG_W-1:0] angle_t;
    typedef logic [DEF_ADC_W-1:0] voltage_t;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter that stops at zero; shared by every mechanical settling dwell.
module settle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] count;
    assign zero = count == '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= value;
        else if (!zero)
            count <= count - W'(1);
    end
endmodule

// File: rtl/sweep_scan_controller.sv
// sweep_scan_controller: raster pan/tilt scan that records the peak panel voltage and parks on it.
module sweep_scan_controller
    import sunflower_pkg::*;
#(
    parameter int ADC_W          = DEF_ADC_W,
    parameter int ANG_W          = DEF_ANG_W,
    parameter int THETA_STEPS    = 12,
    parameter int PHI_STEPS      = 6,
    parameter int THETA_STEP_DEG = 15,
    parameter int PHI_STEP_DEG   = 15,
    parameter int SETTLE_CYCLES  = 50000,
    parameter int ADC_TIMEOUT    = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [ADC_W-1:0] adc_value,
    input  logic             adc_valid,
    output logic             adc_req,
    output logic [ANG_W-1:0] theta_cmd,
    output logic [ANG_W-1:0] phi_cmd,
    output logic             busy,
    output logic             done,
    output logic [ADC_W-1:0] best_voltage,
    output logic [ANG_W-1:0] best_theta,
    output logic [ANG_W-1:0] best_phi,
    output logic             adc_err
);
    localparam int TIW = $clog2(THETA_STEPS + 1);
    localparam int PIW = $clog2(PHI_STEPS + 1);
    localparam int SW  = $clog2(SETTLE_CYCLES + 1);
    localparam int TOW = $clog2(ADC_TIMEOUT + 1);

    scan_state_t    state, next_state;
    logic [TIW-1:0] theta_idx;
    logic [PIW-1:0] phi_idx;
    logic [TOW-1:0] tmo;
    logic           timer_load, timer_zero, theta_last, phi_last;

    assign theta_last = theta_idx == TIW'(THETA_STEPS - 1);
    assign phi_last   = phi_idx == PIW'(PHI_STEPS - 1);

    // Loaded with one less than the dwell so the zero flag lands on the last settle cycle.
    settle_timer #(.W(SW)) u_settle (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .value (SW'(SETTLE_CYCLES - 1)),
        .zero  (timer_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:        next_state = start ? MOVE : IDLE;
            MOVE:        next_state = SETTLE;
            SETTLE:      next_state = timer_zero ? SAMPLE : SETTLE;
            SAMPLE:      next_state = WAIT_ADC;
            WAIT_ADC:    next_state = (adc_valid || tmo == '0) ? NEXT : WAIT_ADC;
            NEXT:        next_state = (theta_last && phi_last) ? PARK : MOVE;
            PARK:        next_state = PARK_SETTLE;
            PARK_SETTLE: next_state = timer_zero ? DONE : PARK_SETTLE;
            DONE:        next_state = IDLE;
            default:     next_state = IDLE;
        endcase
        if (abort)
            next_state = IDLE;
        timer_load = state == MOVE || state == PARK;
        busy       = state != IDLE;
        adc_req    = state == SAMPLE && !abort;
        done       = state == DONE && !abort;
    end

    // Abort freezes the datapath so angles and partial best results hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            theta_idx    <= '0;
            phi_idx      <= '0;
            theta_cmd    <= '0;
            phi_cmd      <= '0;
            tmo          <= '0;
            best_voltage <= '0;
            best_theta   <= '0;
            best_phi     <= '0;
            adc_err      <= 1'b0;
        end else if (!abort) begin
            case (state)
                IDLE: if (start) begin
                    theta_idx    <= '0;
                    phi_idx      <= '0;
                    theta_cmd    <= '0;
                    phi_cmd      <= '0;
                    best_voltage <= '0;
                    best_theta   <= '0;
                    best_phi     <= '0;
                    adc_err      <= 1'b0;
                end
                SAMPLE: tmo <= TOW'(ADC_TIMEOUT - 1);
                WAIT_ADC: begin
                    if (adc_valid) begin
                        if (adc_value > best_voltage) begin
                            best_voltage <= adc_value;
                            best_theta   <= theta_cmd;
                            best_phi     <= phi_cmd;
                        end
                    end else if (tmo == '0)
                        adc_err <= 1'b1;
                    else
                        tmo <= tmo - TOW'(1);
                end
                NEXT: begin
                    if (!theta_last) begin
                        theta_idx <= theta_idx + TIW'(1);
                        theta_cmd <= theta_cmd + ANG_W'(THETA_STEP_DEG);
                    end else begin
                        theta_idx <= '0;
                        theta_cmd <= '0;
                        if (!phi_last) begin
                            phi_idx <= phi_idx + PIW'(1);
                            phi_cmd <= phi_cmd + ANG_W'(PHI_STEP_DEG);
                        end
                    end
                end
                PARK: begin
                    theta_cmd <= best_theta;
                    phi_cmd   <= best_phi;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sweep_scan_controller.sv
// tb_sweep_scan_controller: directed scan scenarios on a 4x3 grid with an ADC responder model.
module tb_sweep_scan_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] adc_value;
    logic        adc_valid;
    logic        adc_req, busy, done, adc_err;
    logic [7:0]  theta_cmd, phi_cmd, best_theta, best_phi;
    logic [11:0] best_voltage;

    int passed = 0, total = 0, failed = 0;
    int req_count = 0, req_base = 0, skip_point = 0, lat = 1, mode = 1;
    int stray_n = 0, stray_seen = 0, pend = 0, n = 0, k = 0;
    logic [11:0] val_q = '0;

    always #5 clk = ~clk;

    sweep_scan_controller #(
        .ADC_W(12), .ANG_W(8), .THETA_STEPS(4), .PHI_STEPS(3),
        .THETA_STEP_DEG(15), .PHI_STEP_DEG(15), .SETTLE_CYCLES(3), .ADC_TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .adc_value(adc_value), .adc_valid(adc_valid), .adc_req(adc_req),
        .theta_cmd(theta_cmd), .phi_cmd(phi_cmd), .busy(busy), .done(done),
        .best_voltage(best_voltage), .best_theta(best_theta), .best_phi(best_phi),
        .adc_err(adc_err)
    );

    function automatic logic [11:0] model(input int m, input int th, input int ph);
        case (m)
            1: return (th == 30 && ph == 15) ? 12'd900 : 12'd100;
            2: return ((th == 15 && ph == 0) || (th == 45 && ph == 30)) ? 12'd700 : 12'd100;
            3: return (th == 0 && ph == 15) ? 12'd900 : (th == 45 && ph == 30) ? 12'd200 : 12'd100;
            default: return 12'(th + 4 * ph + 1);
        endcase
    endfunction

    // ADC responder: answers each request lat cycles later, except the skipped point.
    initial begin
        adc_valid = 1'b0;
        adc_value = '0;
        forever begin
            @(negedge clk);
            adc_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    adc_valid = 1'b1;
                    adc_value = val_q;
                end
            end
            if (stray_seen != stray_n) begin
                stray_seen = stray_n;
                adc_valid  = 1'b1;
                adc_value  = 12'd4000;
            end
            if (adc_req) begin
                req_count++;
                if (req_count - req_base != skip_point) begin
                    pend  = lat;
                    val_q = model(mode, int'(theta_cmd), int'(phi_cmd));
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic zero_checks(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_adc_req"}, adc_req, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_theta_cmd"}, theta_cmd, 0);
        check({tag, "_phi_cmd"}, phi_cmd, 0);
        check({tag, "_best_v"}, best_voltage, 0);
        check({tag, "_best_t"}, best_theta, 0);
        check({tag, "_best_p"}, best_phi, 0);
        check({tag, "_adc_err"}, adc_err, 0);
    endtask

    // Cycle 1 is the MOVE cycle right after the start edge; busy-time start pulses must be ignored.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            start = (cyc == 10 || cyc == 50);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
    endtask

    task automatic run_scan(output int cyc);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        zero_checks("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        mode = 1; lat = 1; req_base = req_count;
        run_scan(n);
        check("t1_reqs", req_count - req_base, 12);
        check("t1_best_v", best_voltage, 900);
        check("t1_best_t", best_theta, 30);
        check("t1_best_p", best_phi, 15);
        check("t1_theta_cmd", theta_cmd, 30);
        check("t1_phi_cmd", phi_cmd, 15);
        check("t1_adc_err", adc_err, 0);
        @(posedge clk);
        #1;
        check("t1_done_single", done, 0);
        check("t1_idle", busy, 0);

        mode = 2; req_base = req_count;
        run_scan(n);
        check("t2_best_v", best_voltage, 700);
        check("t2_best_t", best_theta, 15);
        check("t2_best_p", best_phi, 0);
        @(posedge clk);
        #1;

        mode = 3; skip_point = 5; req_base = req_count;
        run_scan(n);
        check("t3_reqs", req_count - req_base, 12);
        check("t3_adc_err", adc_err, 1);
        check("t3_best_v", best_voltage, 200);
        check("t3_best_t", best_theta, 45);
        check("t3_best_p", best_phi, 30);
        @(posedge clk);
        #1;

        mode = 4; skip_point = 2; req_base = req_count;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (req_count - req_base < 6 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("t4_reached_p6", req_count - req_base, 6);
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        abort = 1'b0;
        check("t4_theta_cmd", theta_cmd, 30);
        check("t4_phi_cmd", phi_cmd, 15);
        check("t4_best_v", best_voltage, 76);
        check("t4_best_t", best_theta, 15);
        check("t4_best_p", best_phi, 15);
        check("t4_adc_err_held", adc_err, 1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_still_idle", busy, 0);
        skip_point = 0; req_base = req_count;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t4_restart_busy", busy, 1);
        check("t4_restart_best_v", best_voltage, 0);
        check("t4_restart_adc_err", adc_err, 0);
        check("t4_restart_theta", theta_cmd, 0);
        wait_done(n);
        check("t4_full_best_v", best_voltage, 166);
        check("t4_full_best_t", best_theta, 45);
        check("t4_full_best_p", best_phi, 30);
        @(posedge clk);
        #1;

        mode = 1; lat = 2; req_base = req_count;
        run_scan(n);
        check("t5_cycles", n, 101);
        check("t5_reqs", req_count - req_base, 12);
        check("t5_best_v", best_voltage, 900);
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("t5_start_abort_idle", busy, 0);
        @(posedge clk);
        #1;
        check("t5_no_late_start", busy, 0);

        mode = 4; lat = 5; req_base = req_count;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (req_count - req_base < 6 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("t6_reached_p6", req_count - req_base, 6);
        check("t6_pre_busy", busy, 1);
        check("t6_pre_best_v", best_voltage, 61);
        check("t6_pre_theta", theta_cmd, 15);
        reset = 1'b1;
        #1;
        zero_checks("t6");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        stray_n++;
        repeat (6) @(posedge clk);
        #1;
        check("t6_stray_busy", busy, 0);
        check("t6_stray_best_v", best_voltage, 0);
        check("t6_stray_best_t", best_theta, 0);
        check("t6_stray_adc_err", adc_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
